// File: rtl/arb2_mux.sv
// -----------------------------------------------------------------------------
// arb2_mux
//
// Two-input arbitrating selector. Two request channels (a, b) offer WIDTH-bit
// words with valid/ready handshakes. A combinational arbiter picks one channel.
// The chosen word is captured into a single output register that has its own
// valid/ready handshake. The captured word stays stable until the consumer
// accepts it.
//
// Handshake semantics (all three channels):
//   A transfer happens on a rising clk edge where both valid and ready are 1.
//   A producer holds its data stable while valid=1 and ready=0.
//   a_ready and b_ready are combinational. They depend on y_ready and on the
//   arbitration result. They are 0 while rst=1. At most one of them is high.
//
// Configuration:
//   ARB2_FIXED_PRIO_EN  When defined, A always wins a tie and the last-grant
//                       register is removed. When undefined (default), ties
//                       are resolved round-robin.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   a        in   channel A data          [WIDTH-1:0]
//   a_valid  in   channel A word offered
//   a_ready  out  channel A word taken this cycle
//   b        in   channel B data          [WIDTH-1:0]
//   b_valid  in   channel B word offered
//   b_ready  out  channel B word taken this cycle
//   y        out  registered selected word [WIDTH-1:0]
//   y_valid  out  y holds an unconsumed word
//   y_ready  in   consumer accepts y
//   s        out  source of current y: 0 = A, 1 = B
// -----------------------------------------------------------------------------
module arb2_mux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             s
);

  logic load;       // output slot can take a word this cycle
  logic grant_a;
  logic grant_b;
  logic grant_any;
  logic s_next;     // index of the granted channel

  // The slot is free when it is empty, or when its word leaves this cycle.
  assign load = ~y_valid | y_ready;

`ifdef ARB2_FIXED_PRIO_EN
  // Fixed priority: A wins whenever it is valid.
  always_comb begin
    grant_a = a_valid;
    grant_b = b_valid & ~a_valid;
  end
`else
  // last_grant holds the index of the most recent real grant.
  // It resets to 1 (B), so A wins the first tie.
  logic last_grant;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      // On a tie, grant the channel that was not granted last time.
      grant_a = last_grant;
      grant_b = ~last_grant;
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  // This register changes only on an actual capture. Idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (load && grant_any) begin
      last_grant <= s_next;
    end
  end
`endif

  assign grant_any = grant_a | grant_b;
  assign s_next    = grant_b;

  // Readies are forced low in reset, so no handshake completes in that cycle.
  assign a_ready = ~rst & load & grant_a;
  assign b_ready = ~rst & load & grant_b;

  // Output register.
  // Capture when the slot is free and there is a grant.
  // Drain when the slot is free and there is no grant; y and s keep their
  // last value. Otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      s       <= 1'b0;
    end else if (load) begin
      if (grant_any) begin
        y       <= s_next ? b : a;
        s       <= s_next;
        y_valid <= 1'b1;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb2_mux.sv
// -----------------------------------------------------------------------------
// tb_arb2_mux
//
// Directed bench for arb2_mux.
//
// The bench keeps its own model of the arbiter: the output-valid flag and the
// last grant. Each cycle it uses this model to predict a_ready and b_ready.
// When it predicts a handshake, it pushes the expected {s, y} onto exp_q.
// While the model says y holds a word, y and s are compared against the front
// of the queue. The front entry is popped when the consumer accepts it.
//
// Inputs change on the falling edge. Outputs are sampled 1ns later, well away
// from the rising edge.
// -----------------------------------------------------------------------------
module tb_arb2_mux;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] b;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] y;
  logic         y_valid;
  logic         y_ready;
  logic         s;

  arb2_mux #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .s       (s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W:0] exp_q[$];   // {s, y}
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic m_yv;
  logic m_last;
  logic m_post_rst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold rst=1 for n cycles while offering words on both channels.
  // The readies must stay 0 throughout.
  task automatic rst_cycles(input int n, input logic av, input logic bv);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; a_valid = av; b_valid = bv; a = 8'hA5; b = 8'h5A; y_ready = 1'b1;
      #1;
      chk("rst_a_ready", a_ready, 1'b0);
      chk("rst_b_ready", b_ready, 1'b0);
    end
    m_yv = 1'b0;
    m_last = 1'b1;
    m_post_rst = 1'b1;
    exp_q.delete();
  endtask

  // One directed cycle: drive inputs, check outputs against the model,
  // then advance the model to match the coming rising edge.
  task automatic cyc(input logic av, input logic [W-1:0] ad,
                     input logic bv, input logic [W-1:0] bd,
                     input logic yr);
    logic ld, ga, gb;
    @(negedge clk);
    rst = 1'b0; a_valid = av; a = ad; b_valid = bv; b = bd; y_ready = yr;
    #1;
    if (m_post_rst) begin
      chk("post_rst_y", y, '0);
      chk("post_rst_s", s, 1'b0);
      m_post_rst = 1'b0;
    end
    chk("y_valid", y_valid, m_yv);
    if (m_yv) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_nonempty", 32'd0, 32'd1);
      end else begin
        chk("y", y, exp_q[0][W-1:0]);
        chk("s", s, exp_q[0][W]);
      end
    end
    ld = ~m_yv | yr;
`ifdef ARB2_FIXED_PRIO_EN
    ga = av;
    gb = bv & ~av;
`else
    if (av && bv) begin
      ga = m_last;
      gb = ~m_last;
    end else begin
      ga = av;
      gb = bv;
    end
`endif
    chk("a_ready", a_ready, ld & ga);
    chk("b_ready", b_ready, ld & gb);
    if (m_yv && yr && exp_q.size() != 0) void'(exp_q.pop_front());
    if (ld && (ga || gb)) begin
      exp_q.push_back({gb, gb ? bd : ad});
      m_yv = 1'b1;
      m_last = gb;
    end else if (ld) begin
      m_yv = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    m_yv = 1'b0; m_last = 1'b1; m_post_rst = 1'b0;

    // Reset held for two cycles, with both channels valid.
    rst_cycles(2, 1'b1, 1'b1);

    // Contention: A and B both valid, consumer always ready.
    // Expect grants to alternate A, B, A, B.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'b1000_0000, 1'b1, 8'b0000_0001, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Single source A, then drop a_valid so the slot drains.
    cyc(1'b1, 8'b1111_0000, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Backpressure: capture A, stall for 3 cycles while B waits, then release.
    cyc(1'b1, 8'b0000_1111, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 8'b1100_1100, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 8'b1100_1100, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 3) != 0));

    // Reset mid-operation: hold a word (consumer stalled) and reset for one
    // cycle. The next tie must go to A.
    cyc(1'b1, 8'b1111_0000, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rst_cycles(1, 1'b0, 1'b0);
    cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    cyc(1'b1, 8'h33, 1'b1, 8'h44, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
